// File: rtl/mem_wb_stage_buf.sv
// Elastic MEM->WB pipeline stage: valid/ready handshake with a two-entry
// skid buffer, flush, bubble-safe write-enable and a saturating stall counter.
module mem_wb_stage_buf #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    // MEM side
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    mem_data_in,
    input  logic [XLEN-1:0]    alu_result_in,
    input  logic [RADDR_W-1:0] rd_in,
    input  logic               RegWrite_in,
    input  logic               MemtoReg_in,
    input  logic               flush,
    // WB side
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    mem_data_out,
    output logic [XLEN-1:0]    alu_result_out,
    output logic [RADDR_W-1:0] rd_out,
    output logic               RegWrite_out,
    output logic               MemtoReg_out,
    output logic [XLEN-1:0]    wb_data,
    output logic               wb_we,
    output logic [CNT_W-1:0]   stall_count
);

    logic main_v;
    logic skid_v;
    logic main_v_nxt;
    logic skid_v_nxt;

    logic load_main_from_skid;
    logic load_main_from_in;
    logic load_skid;

    logic acc;
    logic drn;

    logic [XLEN-1:0]    skid_mem_data;
    logic [XLEN-1:0]    skid_alu_result;
    logic [RADDR_W-1:0] skid_rd;
    logic               skid_reg_write;
    logic               skid_memto_reg;

    // Handshake terms; in_ready comes straight from the skid valid flop
    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign acc       = in_valid & ~skid_v;
    assign drn       = main_v & out_ready;

    // Occupancy next-state and payload load selects; flush has priority
    always_comb begin
        main_v_nxt          = main_v;
        skid_v_nxt          = skid_v;
        load_main_from_skid = 1'b0;
        load_main_from_in   = 1'b0;
        load_skid           = 1'b0;
        if (flush) begin
            main_v_nxt = 1'b0;
            skid_v_nxt = 1'b0;
        end else if (!main_v || drn) begin
            if (skid_v) begin
                main_v_nxt          = 1'b1;
                load_main_from_skid = 1'b1;
                skid_v_nxt          = acc;
                load_skid           = acc;
            end else begin
                main_v_nxt        = acc;
                load_main_from_in = acc;
                skid_v_nxt        = 1'b0;
            end
        end else if (acc) begin
            skid_v_nxt = 1'b1;
            load_skid  = 1'b1;
        end
    end

    // Valid bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            main_v <= main_v_nxt;
            skid_v <= skid_v_nxt;
        end
    end

    // Main payload register; skid entry takes precedence to keep FIFO order
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_data_out   <= '0;
            alu_result_out <= '0;
            rd_out         <= '0;
            RegWrite_out   <= 1'b0;
            MemtoReg_out   <= 1'b0;
        end else if (load_main_from_skid) begin
            mem_data_out   <= skid_mem_data;
            alu_result_out <= skid_alu_result;
            rd_out         <= skid_rd;
            RegWrite_out   <= skid_reg_write;
            MemtoReg_out   <= skid_memto_reg;
        end else if (load_main_from_in) begin
            mem_data_out   <= mem_data_in;
            alu_result_out <= alu_result_in;
            rd_out         <= rd_in;
            RegWrite_out   <= RegWrite_in;
            MemtoReg_out   <= MemtoReg_in;
        end
    end

    // Skid payload register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_mem_data   <= '0;
            skid_alu_result <= '0;
            skid_rd         <= '0;
            skid_reg_write  <= 1'b0;
            skid_memto_reg  <= 1'b0;
        end else if (load_skid) begin
            skid_mem_data   <= mem_data_in;
            skid_alu_result <= alu_result_in;
            skid_rd         <= rd_in;
            skid_reg_write  <= RegWrite_in;
            skid_memto_reg  <= MemtoReg_in;
        end
    end

    // Saturating count of cycles where a held entry is not consumed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (main_v && !out_ready && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    // Write-back mux and enable; bubbles and x0 never write
    assign wb_data = MemtoReg_out ? mem_data_out : alu_result_out;
    assign wb_we   = main_v & RegWrite_out & (rd_out != '0);

endmodule
